reel_adc_sampler: RTL and testbench

Upstream front end for the fishing game controller. It drives a 12-bit serial ADC (AD7476-style Pmod, 16-clock frame) that digitises the reel sensor, and averages 2^AVG_LOG2 conversions. It presents a held 9-bit `reel` magnitude, plus a decoded 2-bit speed level, to the game controller's `reel[8:0]` input. Free-running: conversions repeat continuously after reset.

---
 rtl/reel_adc_sampler.sv | 140 ++++++++++++++
 tb/tb_reel_adc_sampler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reel_adc_sampler.sv
// Reel sensor front end: drives a 16-clock serial ADC frame, averages
// 2^AVG_LOG2 conversions and presents a held 9-bit magnitude and speed level.
module reel_adc_sampler #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SAMPLE_GAP = 16,
    parameter int unsigned AVG_LOG2   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       miso_i,
    output logic       cs_n_o,
    output logic       sclk_o,
    output logic [8:0] reel_o,
    output logic [1:0] reel_level_o,
    output logic       reel_valid_o,
    output logic       busy_o
);

    localparam int unsigned AccW = 12 + AVG_LOG2;
    localparam int unsigned FrmW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned GapW = $clog2(SAMPLE_GAP + 1);
    localparam int unsigned DivW = $clog2(CLK_DIV + 1);

    localparam logic [GapW-1:0] GapLast = GapW'(SAMPLE_GAP - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [FrmW-1:0] FrmLast = FrmW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {StGap, StStart, StShift, StDone} state_e;

    state_e            state_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic [DivW-1:0]   div_cnt_q;
    logic [5:0]        half_cnt_q;
    logic [11:0]       shift_q;
    logic [AccW-1:0]   acc_q;
    logic [FrmW-1:0]   frame_cnt_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              busy_q;
    logic [8:0]        reel_q;
    logic [1:0]        reel_level_q;
    logic              reel_valid_q;

    logic [AccW-1:0]   acc_sum;
    logic [8:0]        reel_new;
    logic [1:0]        reel_level_d;
    logic              load;

    // Running sum including the frame just shifted in, and the level decode of its top bits.
    always_comb begin
        acc_sum      = acc_q + AccW'(shift_q);
        reel_new     = acc_sum[AccW-1 -: 9];
        load         = (AVG_LOG2 == 0) || (frame_cnt_q == FrmLast);
        reel_level_d = 2'd0;
        if (reel_new[8:5] >= 4'd10) begin
            reel_level_d = 2'd2;
        end else if (reel_new[8:5] == 4'd9) begin
            reel_level_d = 2'd1;
        end
    end

    // Frame sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StGap;
            gap_cnt_q    <= '0;
            div_cnt_q    <= '0;
            half_cnt_q   <= '0;
            shift_q      <= '0;
            acc_q        <= '0;
            frame_cnt_q  <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            busy_q       <= 1'b0;
            reel_q       <= '0;
            reel_level_q <= '0;
            reel_valid_q <= 1'b0;
        end else begin
            reel_valid_q <= 1'b0;
            unique case (state_q)
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q    <= StStart;
                        gap_cnt_q  <= '0;
                        div_cnt_q  <= '0;
                        half_cnt_q <= '0;
                        shift_q    <= '0;
                        cs_n_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end
                // START counts as the first cycle of the SCLK timebase so that
                // toggle n lands exactly n*CLK_DIV cycles after cs_n falls.
                StStart, StShift: begin
                    if (state_q == StShift && half_cnt_q == 6'd32) begin
                        state_q <= StDone;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StShift;
                        if (div_cnt_q == DivLast) begin
                            div_cnt_q  <= '0;
                            sclk_q     <= ~sclk_q;
                            half_cnt_q <= half_cnt_q + 6'd1;
                            // Low-to-high edge: only the last 12 bits survive the shift.
                            if (!sclk_q) begin
                                shift_q <= {shift_q[10:0], miso_i};
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + DivW'(1);
                        end
                    end
                end
                StDone: begin
                    state_q     <= StGap;
                    frame_cnt_q <= (AVG_LOG2 == 0) ? '0 : frame_cnt_q + FrmW'(1);
                    if (load) begin
                        acc_q        <= '0;
                        reel_q       <= reel_new;
                        reel_level_q <= reel_level_d;
                        reel_valid_q <= 1'b1;
                    end else begin
                        acc_q <= acc_sum;
                    end
                end
                default: state_q <= StGap;
            endcase
        end
    end

    assign cs_n_o       = cs_n_q;
    assign sclk_o       = sclk_q;
    assign busy_o       = busy_q;
    assign reel_o       = reel_q;
    assign reel_level_o = reel_level_q;
    assign reel_valid_o = reel_valid_q;

endmodule

// File: tb/tb_reel_adc_sampler.sv
// Directed bench: default-parameter sampler plus a fast (1,1,0) instance, each fed
// by a small serial ADC model returning a per-frame 16-bit word.
module tb_reel_adc_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst_a = 1'b1;
    logic       miso_a = 1'b0;
    logic       cs_n_a, sclk_a, valid_a, busy_a;
    logic [8:0] reel_a;
    logic [1:0] level_a;

    // Fast instance
    logic       rst_b = 1'b1;
    logic       miso_b = 1'b0;
    logic       cs_n_b, sclk_b, valid_b, busy_b;
    logic [8:0] reel_b;
    logic [1:0] level_b;

    reel_adc_sampler dut_a (
        .clk_i(clk), .rst_i(rst_a), .miso_i(miso_a), .cs_n_o(cs_n_a), .sclk_o(sclk_a),
        .reel_o(reel_a), .reel_level_o(level_a), .reel_valid_o(valid_a), .busy_o(busy_a)
    );

    reel_adc_sampler #(.CLK_DIV(1), .SAMPLE_GAP(1), .AVG_LOG2(0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .miso_i(miso_b), .cs_n_o(cs_n_b), .sclk_o(sclk_b),
        .reel_o(reel_b), .reel_level_o(level_b), .reel_valid_o(valid_b), .busy_o(busy_b)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ADC models: word captured at cs_n fall, bit 15 presented on the first SCLK fall.
    logic [15:0] pat_a[4];
    logic [15:0] pat_b[4];
    logic [15:0] word_a, word_b;
    int frames_a = 0, base_a = 0, bit_a = -1;
    int frames_b = 0, base_b = 0, bit_b = -1;

    always @(negedge cs_n_a or negedge sclk_a) begin
        if (cs_n_a === 1'b0) begin
            if (sclk_a) begin
                word_a = pat_a[(frames_a - base_a) % 4];
                frames_a++;
                bit_a = 15;
            end else if (bit_a >= 0) begin
                miso_a = word_a[bit_a];
                bit_a--;
            end
        end
    end

    always @(negedge cs_n_b or negedge sclk_b) begin
        if (cs_n_b === 1'b0) begin
            if (sclk_b) begin
                word_b = pat_b[(frames_b - base_b) % 4];
                frames_b++;
                bit_b = 15;
            end else if (bit_b >= 0) begin
                miso_b = word_b[bit_b];
                bit_b--;
            end
        end
    end

    // SCLK protocol monitor on the default instance.
    logic rst_seen_a;
    always @(posedge clk) rst_seen_a <= rst_a;

    bit mon_on = 1'b0;
    logic mon_cs = 1'b1, mon_sclk = 1'b1;
    int rises = 0, wins_seen = 0, win_bad = 0, proto_bad = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (cs_n_a && !sclk_a) proto_bad++;
            if (busy_a !== !cs_n_a) proto_bad++;
            if (mon_cs && !cs_n_a) rises = 0;
            if (!mon_sclk && sclk_a && !cs_n_a) rises++;
            if (!mon_cs && cs_n_a && !rst_seen_a) begin
                wins_seen++;
                if (rises != 16) win_bad++;
            end
        end
        mon_cs   = cs_n_a;
        mon_sclk = sclk_a;
    end

    task automatic reset_a();
        @(negedge clk);
        rst_a  = 1'b1;
        base_a = frames_a;
        @(negedge clk);
        rst_a  = 1'b0;
    endtask

    typedef struct {
        logic [15:0] w0, w1, w2, w3;
        int          reel;
        int          level;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n, t_s1, t_s2, t_v1, t_v2, r1, l1, r2, r;
        logic ps, pc;

        vecs[0] = '{16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF, 511, 2};
        vecs[1] = '{16'h0800, 16'h0800, 16'h0800, 16'h0800, 256, 0};
        vecs[2] = '{16'h0960, 16'h0960, 16'h0960, 16'h0960, 300, 1};
        vecs[3] = '{16'hF000, 16'hF000, 16'hF000, 16'hF000, 0,   0};
        vecs[4] = '{16'h0000, 16'h0FFF, 16'h0000, 16'h0FFF, 255, 0};
        vecs[5] = '{16'h0A00, 16'h0A00, 16'h0A00, 16'h0A00, 320, 2};
        vecs[6] = '{16'h09FF, 16'h09FF, 16'h09FF, 16'h09FF, 319, 1};
        vecs[7] = '{16'h08FF, 16'h08FF, 16'h08FF, 16'h08FF, 287, 0};
        vecs[8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 80,  0};
        vecs[9] = '{16'hA555, 16'hA555, 16'hA555, 16'hA555, 170, 0};

        for (int k = 0; k < 4; k++) pat_a[k] = 16'h0FFF;
        pat_b[0] = 16'h0001;
        pat_b[1] = 16'h0008;
        pat_b[2] = 16'h0FF8;
        pat_b[3] = 16'hF000;

        // Reset state, first START, frame period and update period with 0xFFF samples.
        reset_a();
        mon_on = 1'b1;
        check("reset cs_n", int'(cs_n_a), 1);
        check("reset sclk", int'(sclk_a), 1);
        check("reset busy", int'(busy_a), 0);
        check("reset valid", int'(valid_a), 0);
        check("reset reel", int'(reel_a), 0);

        n = 0; t_s1 = -1; t_s2 = -1; t_v1 = -1; t_v2 = -1; r1 = 0; l1 = 0; r2 = 0;
        pc = 1'b1;
        while (n < 1400 && t_v2 < 0) begin
            @(negedge clk);
            n++;
            if (pc && !cs_n_a) begin
                if (t_s1 < 0) t_s1 = n;
                else if (t_s2 < 0) t_s2 = n;
            end
            pc = cs_n_a;
            if (valid_a) begin
                if (t_v1 < 0) begin t_v1 = n; r1 = int'(reel_a); l1 = int'(level_a); end
                else begin t_v2 = n; r2 = int'(reel_a); end
            end
        end
        check("first START cycle", t_s1, 16);
        check("frame period", t_s2 - t_s1, 146);
        check("first valid cycle", t_v1, 584);
        check("valid period", t_v2 - t_v1, 584);
        check("reel 0xFFF", r1, 511);
        check("level 0xFFF", l1, 2);
        check("reel 0xFFF second update", r2, 511);

        // Reset at the 7th rising SCLK edge of frame 2.
        for (int f = 0; f < 2; f++) begin
            n = 0;
            pc = cs_n_a;
            while (n < 400 && !(pc && !cs_n_a)) begin
                pc = cs_n_a;
                @(negedge clk);
                n++;
            end
        end
        r = 0; n = 0; ps = sclk_a;
        while (r < 7 && n < 400) begin
            @(negedge clk);
            n++;
            if (!ps && sclk_a) r++;
            ps = sclk_a;
        end
        check("mid-shift edge reached", r, 7);
        rst_a  = 1'b1;
        base_a = frames_a;
        @(negedge clk);
        check("mid-shift reset cs_n", int'(cs_n_a), 1);
        check("mid-shift reset sclk", int'(sclk_a), 1);
        check("mid-shift reset busy", int'(busy_a), 0);
        check("mid-shift reset valid", int'(valid_a), 0);
        check("mid-shift reset reel", int'(reel_a), 0);
        check("mid-shift reset level", int'(level_a), 0);
        rst_a = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!valid_a && n < 700);
        check("valid after mid-shift reset", n, 584);
        check("reel after mid-shift reset", int'(reel_a), 511);

        // Table of per-frame sample patterns.
        foreach (vecs[i]) begin
            pat_a[0] = vecs[i].w0;
            pat_a[1] = vecs[i].w1;
            pat_a[2] = vecs[i].w2;
            pat_a[3] = vecs[i].w3;
            reset_a();
            n = 0;
            do begin @(negedge clk); n++; end while (!valid_a && n < 700);
            check($sformatf("vec%0d valid cycle", i), n, 584);
            check($sformatf("vec%0d reel", i), int'(reel_a), vecs[i].reel);
            check($sformatf("vec%0d level", i), int'(level_a), vecs[i].level);
        end

        // Fast instance: one conversion per update, 35-cycle frames.
        @(negedge clk);
        rst_b  = 1'b1;
        base_b = frames_b;
        @(negedge clk);
        rst_b  = 1'b0;
        for (int f = 0; f < 4; f++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!valid_b && n < 100);
            check($sformatf("fast frame%0d period", f), n, 35);
            check($sformatf("fast frame%0d reel", f), int'(reel_b),
                  (f == 0) ? 0 : (f == 1) ? 1 : (f == 2) ? 511 : 0);
            check($sformatf("fast frame%0d level", f), int'(level_b), (f == 2) ? 2 : 0);
        end

        check("sclk/cs_n/busy protocol violations", proto_bad, 0);
        check("windows without 16 rising edges", win_bad, 0);
        check("enough cs_n windows observed", (wins_seen >= 20) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
